inst_mem: RTL and testbench

Instruction memory: the responder side of the fetch-stage memory interface.
- Returns a 32-bit instruction combinationally for the fetch address, so the read has the same-cycle semantics fetch expects.
- Contains a byte-serial loader (valid/ready stream) that fills memory after reset. The loader assembles little-endian words and holds the core via ld_busy until the program is written.

---
 rtl/utils_top.sv | 15 +
 rtl/inst_mem_if.sv | 33 +++
 rtl/inst_mem_byte_asm.sv | 42 ++++
 rtl/inst_mem.sv | 131 +++++++++++++
 tb/tb_inst_mem.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/utils_top.sv
// rtl/utils_top.sv - shared constants and loader state type for the instruction memory
// Contents:
//   BUBBLE     - NOP instruction (addi x0,x0,0) returned when no valid instruction exists
//   ld_state_t - byte-loader state encoding
package utils_top;

    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } ld_state_t;

endpackage

// File: rtl/inst_mem_if.sv
// rtl/inst_mem_if.sv - fetch and byte-loader bundle between core/loader and inst_mem
// Signals:
//   mem_addr / mem_dat_out      - fetch byte address and the instruction returned for it
//   ld_start / ld_words         - start-load pulse and number of words to load
//   ld_vld / ld_byte / ld_rdy   - byte stream into the memory
//   ld_busy / ld_done / ld_err  - load status back to the core
// Modports: master = core/loader side, slave = memory side.
interface inst_mem_if #(
    parameter int INST_MEM_BYTE_ADD_W = 8
);

    logic [31:0]                    mem_addr;
    logic [31:0]                    mem_dat_out;
    logic                           ld_start;
    logic [INST_MEM_BYTE_ADD_W-2:0] ld_words;
    logic                           ld_vld;
    logic [7:0]                     ld_byte;
    logic                           ld_rdy;
    logic                           ld_busy;
    logic                           ld_done;
    logic                           ld_err;

    modport master (
        output mem_addr, ld_start, ld_words, ld_vld, ld_byte,
        input  mem_dat_out, ld_rdy, ld_busy, ld_done, ld_err
    );

    modport slave (
        input  mem_addr, ld_start, ld_words, ld_vld, ld_byte,
        output mem_dat_out, ld_rdy, ld_busy, ld_done, ld_err
    );

endinterface

// File: rtl/inst_mem_byte_asm.sv
// rtl/inst_mem_byte_asm.sv - assembles little-endian 32-bit words from accepted loader bytes
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - discard any partial word and restart at byte lane 0
//   byte_acc  - a loader byte is accepted this cycle
//   byte_in   - the accepted byte
//   word_vld  - pulse, same cycle as the 4th byte of a word is accepted
//   word      - assembled word, valid while word_vld is high
module inst_mem_byte_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_acc,
    input  logic [7:0]  byte_in,
    output logic        word_vld,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] hold;

    // The 4th byte is never stored: it is combined directly with the three held
    // bytes so the top can write the word on the same edge that accepts it.
    assign word_vld = byte_acc && (byte_cnt == 2'd3);
    assign word     = {byte_in, hold};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_cnt <= 2'd0;
            hold     <= 24'd0;
        end else if (byte_acc) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    hold[7:0]   <= byte_in;
                2'd1:    hold[15:8]  <= byte_in;
                2'd2:    hold[23:16] <= byte_in;
                default: hold        <= hold;
            endcase
        end
    end

endmodule

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - instruction memory with combinational fetch read and byte-serial loader
// Ports:
//   clk  - core clock
//   rst  - synchronous active-high reset (array contents are kept)
//   bus  - inst_mem_if slave: fetch address/data plus loader stream and status
// Parameter:
//   INST_MEM_BYTE_ADD_W - byte address width; depth is 2^(INST_MEM_BYTE_ADD_W-2) words
module inst_mem
    import utils_top::*;
#(
    parameter int INST_MEM_BYTE_ADD_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    inst_mem_if.slave bus
);

    localparam int AW    = INST_MEM_BYTE_ADD_W - 2;
    localparam int CW    = INST_MEM_BYTE_ADD_W - 1;
    localparam int DEPTH = 1 << AW;

    ld_state_t      state;
    ld_state_t      state_n;
    logic [CW-1:0]  words_q;
    logic [AW-1:0]  wptr;
    logic           err_q;
    logic           rdy;
    logic           busy;
    logic           done;
    logic           start_ok;
    logic           byte_acc;
    logic           word_vld;
    logic [31:0]    word;
    logic           last_word;
    logic [AW-1:0]  rd_idx;
    logic           addr_oob;
    logic           unused_addr_bits;

    logic [31:0]    mem [DEPTH];

    // ld_words is one bit wider than the pointer so a full-depth load is expressible.
    assign start_ok  = bus.ld_start && (state == LD_IDLE)
                     && (bus.ld_words != '0) && (bus.ld_words <= CW'(DEPTH));
    assign byte_acc  = bus.ld_vld && rdy;
    assign last_word = ({1'b0, wptr} + CW'(1)) == words_q;

    inst_mem_byte_asm u_byte_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .byte_acc (byte_acc),
        .byte_in  (bus.ld_byte),
        .word_vld (word_vld),
        .word     (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        rdy     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            LD_IDLE: begin
                if (start_ok) begin
                    state_n = LD_LOAD;
                end
            end
            LD_LOAD: begin
                rdy  = 1'b1;
                busy = 1'b1;
                if (word_vld && last_word) begin
                    state_n = LD_DONE;
                end
            end
            LD_DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_n = LD_IDLE;
            end
            default: state_n = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            wptr    <= '0;
            err_q   <= 1'b0;
        end else begin
            // Any start outside IDLE, or with an out-of-range count, is flagged
            // but never disturbs a load already in progress.
            if (bus.ld_start) begin
                if (start_ok) begin
                    words_q <= bus.ld_words;
                    wptr    <= '0;
                    err_q   <= 1'b0;
                end else begin
                    err_q   <= 1'b1;
                end
            end
            if (word_vld) begin
                wptr <= wptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_vld) begin
            mem[wptr] <= word;
        end
    end

    assign rd_idx           = bus.mem_addr[INST_MEM_BYTE_ADD_W-1:2];
    assign addr_oob         = |bus.mem_addr[31:INST_MEM_BYTE_ADD_W];
    assign unused_addr_bits = ^bus.mem_addr[1:0];

    assign bus.mem_dat_out = (addr_oob || busy) ? BUBBLE : mem[rd_idx];
    assign bus.ld_rdy      = rdy;
    assign bus.ld_busy     = busy;
    assign bus.ld_done     = done;
    assign bus.ld_err      = err_q;

endmodule

// File: tb/tb_inst_mem.sv
// tb/tb_inst_mem.sv - randomized self-checking bench for inst_mem against a byte-level model
module tb_inst_mem;
    import utils_top::*;

    localparam int W     = 8;
    localparam int DEPTH = 1 << (W - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_mem_if #(.INST_MEM_BYTE_ADD_W(W)) bus ();

    inst_mem #(.INST_MEM_BYTE_ADD_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: loader progress counted in bytes, memory as an array of words.
    bit          model_ready = 1'b0;
    bit          m_loading   = 1'b0;
    bit          m_done      = 1'b0;
    bit          m_err       = 1'b0;
    int          m_total     = 0;
    int          m_bytes     = 0;
    logic [31:0] m_stage     = '0;
    logic [31:0] m_mem   [DEPTH];
    bit          m_valid [DEPTH];
    bit          was_loading;
    bit          was_idle;

    always @(posedge clk) begin
        if (rst) begin
            m_loading   = 1'b0;
            m_done      = 1'b0;
            m_err       = 1'b0;
            m_bytes     = 0;
            model_ready = 1'b1;
        end else if (model_ready) begin
            was_loading = m_loading;
            was_idle    = !m_loading && !m_done;
            m_done      = 1'b0;
            if (bus.ld_start) begin
                if (was_idle && bus.ld_words >= 1 && int'(bus.ld_words) <= DEPTH) begin
                    m_err     = 1'b0;
                    m_loading = 1'b1;
                    m_total   = int'(bus.ld_words);
                    m_bytes   = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (was_loading && bus.ld_vld) begin
                m_stage[8*(m_bytes%4) +: 8] = bus.ld_byte;
                m_bytes++;
                if (m_bytes % 4 == 0) begin
                    m_mem[m_bytes/4 - 1]   = m_stage;
                    m_valid[m_bytes/4 - 1] = 1'b1;
                end
                if (m_bytes == 4 * m_total) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end
    end

    logic [31:0] exp_dat;
    bit          exp_busy;
    int          widx;

    always @(negedge clk) begin
        if (model_ready) begin
            exp_busy = m_loading || m_done;
            check("ld_rdy",  {31'b0, bus.ld_rdy},  {31'b0, m_loading});
            check("ld_busy", {31'b0, bus.ld_busy}, {31'b0, exp_busy});
            check("ld_done", {31'b0, bus.ld_done}, {31'b0, m_done});
            check("ld_err",  {31'b0, bus.ld_err},  {31'b0, m_err});
            widx = int'(bus.mem_addr[W-1:2]);
            if (exp_busy || (bus.mem_addr >> W) != 0) begin
                check("mem_dat_bubble", bus.mem_dat_out, BUBBLE);
            end else if (m_valid[widx]) begin
                exp_dat = m_mem[widx];
                check("mem_dat", bus.mem_dat_out, exp_dat);
            end
        end
    end

    // Length of the LOAD phase that preceded the most recent ld_done.
    int rdy_run = 0;
    int last_load_len = -1;
    always @(negedge clk) begin
        if (bus.ld_rdy) begin
            rdy_run++;
        end else begin
            if (bus.ld_done) last_load_len = rdy_run;
            rdy_run = 0;
        end
    end

    bit rand_addr = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_addr) begin
            bus.mem_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom) : {24'b0, 8'($urandom)};
        end
    endtask

    logic [7:0] byte_q [$];

    // mode: 0 back-to-back, 1 valid toggling starting low, 2 random valid
    task automatic do_load(input int nwords, input int mode, input int mid_start, input int abort_after);
        int  sent;
        int  budget;
        int  phase;
        bit  acc;
        bit  mid_used;
        bit  got;
        sent     = 0;
        budget   = 0;
        phase    = 0;
        mid_used = 1'b0;
        got      = 1'b0;
        bus.ld_words = (W-1)'(nwords);
        bus.ld_start = 1'b1;
        cyc();
        bus.ld_start = 1'b0;
        while (sent < 4 * nwords && budget < 2000) begin
            if (abort_after >= 0 && sent == abort_after) begin
                bus.ld_vld = 1'b0;
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                return;
            end
            case (mode)
                0:       bus.ld_vld = 1'b1;
                1:       bus.ld_vld = phase[0];
                default: bus.ld_vld = 1'($urandom_range(0, 1));
            endcase
            bus.ld_byte  = byte_q[sent];
            bus.ld_start = (mid_start >= 0 && sent >= mid_start && !mid_used);
            if (bus.ld_start) mid_used = 1'b1;
            acc = bus.ld_vld && bus.ld_rdy;
            cyc();
            if (acc) sent++;
            phase++;
            budget++;
        end
        bus.ld_vld   = 1'b0;
        bus.ld_start = 1'b0;
        if (budget >= 2000) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got %0d bytes expected %0d", sent, 4 * nwords);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            if (bus.ld_done) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no ld_done expected pulse");
        end
        cyc();
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.mem_addr = addr;
        @(negedge clk);
        check(name, bus.mem_dat_out, exp);
        cyc();
    endtask

    task automatic load_prog();
        byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    int n;
    int mid;

    initial begin
        rst          = 1'b1;
        bus.mem_addr = '0;
        bus.ld_start = 1'b0;
        bus.ld_words = '0;
        bus.ld_vld   = 1'b0;
        bus.ld_byte  = '0;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'b0, bus.ld_busy}, 32'd0);
        check("reset_rdy",  {31'b0, bus.ld_rdy},  32'd0);
        check("reset_err",  {31'b0, bus.ld_err},  32'd0);
        cyc();

        // Test 1: back-to-back two-word load
        load_prog();
        do_load(2, 0, -1, -1);
        check("t1_load_len", 32'(last_load_len), 32'd8);
        read_check("t1_word0", 32'h0, 32'h0000_0013);
        read_check("t1_word1", 32'h4, 32'h0010_0093);

        // Test 2: valid toggling every cycle
        load_prog();
        do_load(2, 1, -1, -1);
        check("t2_load_len", 32'(last_load_len), 32'd16);
        read_check("t2_word0", 32'h0, 32'h0000_0013);
        read_check("t2_word1", 32'h4, 32'h0010_0093);

        // Test 3: out-of-range and unaligned addresses
        read_check("t3_oob",       32'h100, BUBBLE);
        read_check("t3_oob_high",  32'h8000_0004, BUBBLE);
        read_check("t3_unaligned", 32'h6, 32'h0010_0093);

        // Test 4: bad word counts
        bus.ld_words = '0;
        bus.ld_start = 1'b1;
        cyc();
        bus.ld_start = 1'b0;
        @(negedge clk);
        check("t4_err_zero",  {31'b0, bus.ld_err},  32'd1);
        check("t4_busy_zero", {31'b0, bus.ld_busy}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.ld_words = 7'd65;
        bus.ld_start = 1'b1;
        cyc();
        bus.ld_start = 1'b0;
        @(negedge clk);
        check("t4_err_65",  {31'b0, bus.ld_err},  32'd1);
        check("t4_busy_65", {31'b0, bus.ld_busy}, 32'd0);
        cyc();
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(1, 0, -1, -1);
        @(negedge clk);
        check("t4_err_cleared", {31'b0, bus.ld_err}, 32'd0);
        cyc();
        read_check("t4_word0", 32'h0, 32'h0403_0201);

        // Test 5: start pulsed mid-load
        load_prog();
        do_load(2, 0, 3, -1);
        @(negedge clk);
        check("t5_err", {31'b0, bus.ld_err}, 32'd1);
        cyc();
        read_check("t5_word0", 32'h0, 32'h0000_0013);
        read_check("t5_word1", 32'h4, 32'h0010_0093);

        // Test 6: reset after five bytes, then a fresh one-word load
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_load(2, 0, -1, 5);
        @(negedge clk);
        check("t6_busy_after_rst", {31'b0, bus.ld_busy}, 32'd0);
        cyc();
        read_check("t6_word0_kept", 32'h0, 32'h4433_2211);
        read_check("t6_word1_kept", 32'h4, 32'h0010_0093);
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_load(1, 0, -1, -1);
        read_check("t6_word0_new", 32'h0, 32'hDDCC_BBAA);

        // Full-depth load, then sweep every word against the model
        byte_q = {};
        for (int i = 0; i < 4 * DEPTH; i++) byte_q.push_back(8'($urandom));
        do_load(DEPTH, 2, -1, -1);
        for (int i = 0; i < DEPTH; i++) begin
            bus.mem_addr = 32'(4 * i + $urandom_range(0, 3));
            cyc();
        end

        // Randomized loads, bad starts and fetch addresses
        rand_addr = 1'b1;
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.ld_words = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(DEPTH + 1, 127));
                bus.ld_start = 1'b1;
                cyc();
                bus.ld_start = 1'b0;
            end else begin
                n = $urandom_range(1, 8);
                byte_q = {};
                for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
                mid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
                do_load(n, 2, mid, -1);
            end
            repeat ($urandom_range(1, 4)) cyc();
        end
        rand_addr = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
